acc_datapath_param: RTL and testbench
=====================================

Name: acc_datapath_param

Overview:
- Parametrised accumulator datapath: WIDTH-bit accumulator, single-cycle ALU ops, and an iterative shift-add multiplier behind a valid/ready operation handshake.
- Replaces hard-wired 16-bit one-hot op strobes and the tri-state ac bus with an encoded opcode, a registered completion pulse, and carry/zero flags.
- Sits between the controller (issues ops) and the data bus (supplies operands, reads the accumulator).

Parameters:
- WIDTH, 16: accumulator/data width. Must be even and >= 4.
- HALF, WIDTH/2 (derived, not overridable): multiplier operand width and iteration count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- op_valid  in  1  op_code/data_in valid this cycle.
- op_ready  out  1  block can accept an op. Equals !busy.
- op_code  in  3  operation select (see Behaviour).
- data_in  in  WIDTH  operand; sampled only on accept.
- acc_out  out  WIDTH  accumulator value, registered.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse, cycle after the accumulator commits any op.
- carry  out  1  carry/shift-out flag, registered.
- zero  out  1  combinational: acc_out == 0.

Behaviour:
- Reset (rst_n low at a rising edge) sets acc_out=0, carry=0, busy=0, done=0, FSM=IDLE, iteration counter=0. This applies in any state and aborts a multiply in progress with no done pulse.
- Accept occurs when op_valid && op_ready at a rising edge. op_valid while busy is ignored and not queued.
- Opcodes:
  - 0 NOP: acc unchanged.
  - 1 CLR: acc=0, carry=0.
  - 2 SHR: logical right shift by 1; carry=acc[0].
  - 3 ADD: {carry,acc} = acc + data_in.
  - 4 INC: {carry,acc} = acc + 1.
  - 5 SWAP: exchange upper and lower HALF bits.
  - 6 CMP: acc = ~acc.
  - 7 MUL: acc = acc[HALF-1:0] * data_in[HALF-1:0], unsigned, full WIDTH-bit product. Upper operand bits are ignored.
- carry changes only on CLR, SHR, ADD and INC; all other ops hold it.
- Opcodes 0-6 (single cycle): acc/carry update on the accept edge. done is high for exactly the following cycle. op_ready stays high, so back-to-back ops every cycle are allowed.
- FSM has two states, IDLE and MUL_RUN.
  - IDLE -> MUL_RUN on accepted MUL: latch multiplicand=acc[HALF-1:0] and multiplier=data_in[HALF-1:0], clear the product register, set counter=0, busy=1.
  - In MUL_RUN, each edge: if multiplier LSB=1, product += multiplicand << counter; shift multiplier right; counter++.
  - MUL_RUN -> IDLE on the edge where counter reaches HALF-1 (the HALF-th iteration). On that edge, acc=final product, busy=0, and done is high for the next cycle.
  - Latency: accept at edge N, acc valid after edge N+HALF, done high in cycle N+HALF. acc_out keeps its old value until commit.
- No early termination on a zero multiplier; latency is always HALF cycles.
- A new op may be accepted in the same cycle done is high, provided op_ready=1.
- Wrap-around: ADD/INC overflow wraps modulo 2^WIDTH and sets carry=1. INC of all-ones gives 0 with carry=1 and zero=1.

Decomposition:
- Package acc_datapath_pkg:
  - op_code localparams: OP_NOP, OP_CLR, OP_SHR, OP_ADD, OP_INC, OP_SWAP, OP_CMP, OP_MUL.
  - FSM state encodings: ST_IDLE, ST_MUL_RUN.
- Sub-module shift_add_multiplier (parameter HALF):
  - Ports: clk, rst_n, start, a, b in; product, busy, done_strobe out.
  - Contains the counter and product register.
- Top level holds the accumulator, ALU mux, flags, handshake and done register.

Test Plan (WIDTH=16):
- Reset, then ADD 0x1234, INC -> acc=0x1235, carry=0, done high one cycle after each accept, op_ready never drops.
- acc=0x0001, ADD 0xFFFF -> acc=0x0000, carry=1, zero=1. Then CLR -> carry=0.
- acc=0x1234, SWAP -> 0x3412. CMP -> 0xCBED. acc=0x0003, SHR -> 0x0001 with carry=1.
- acc=0xAB0F, MUL data_in=0x120F -> operands 0x0F and 0x0F:
  - busy high for 8 cycles, op_ready low for 8 cycles.
  - acc stays 0xAB0F until commit, then becomes 0x00E1, with one done pulse.
  - ADD issued mid-multiply is ignored.
- acc=0x00FF, MUL 0x00FF -> 0xFE01 after exactly 8 cycles. Carry is unchanged from its prior value.
- Reset asserted on the 4th multiply cycle -> next cycle acc=0, busy=0, op_ready=1, and no done pulse. A subsequent MUL runs a full 8 cycles.

Source files
------------

// File: rtl/acc_datapath_pkg.sv
// Shared opcodes and multiplier FSM encodings for the accumulator datapath.
package acc_datapath_pkg;
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_CLR  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_SWAP = 3'd5;
   localparam logic [2:0] OP_CMP  = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } mul_state_e;
endpackage

// File: rtl/acc_datapath_param_mul.sv
// Iterative shift-add multiplier: HALF x HALF -> 2*HALF, one multiplier bit per cycle.
module shift_add_multiplier
   import acc_datapath_pkg::*;
#(
   parameter int HALF = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [HALF-1:0]   a,
   input  logic [HALF-1:0]   b,
   output logic [2*HALF-1:0] product,
   output logic              busy,
   output logic              done_strobe
);
   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   mul_state_e        state_q, state_d;
   logic [HALF-1:0]   a_q, b_q;
   logic [2*HALF-1:0] prod_q, addend;
   logic [CW-1:0]     cnt_q;
   logic              last;

   assign last   = (cnt_q == CW'(HALF-1));
   assign addend = b_q[0] ? ({{HALF{1'b0}}, a_q} << cnt_q) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_MUL_RUN;
         ST_MUL_RUN: if (last)  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // product includes the current iteration, so the owner can commit it on done_strobe
   always_comb begin
      busy        = (state_q == ST_MUL_RUN);
      done_strobe = busy && last;
      product     = prod_q + addend;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == ST_IDLE && start) begin
         a_q    <= a;
         b_q    <= b;
         prod_q <= '0;
         cnt_q  <= '0;
      end else if (state_q == ST_MUL_RUN) begin
         prod_q <= prod_q + addend;
         b_q    <= b_q >> 1;
         cnt_q  <= cnt_q + CW'(1);
      end
   end
endmodule

// File: rtl/acc_datapath_param.sv
// Accumulator with single-cycle ALU ops and a multi-cycle multiply behind op_valid/op_ready.
module acc_datapath_param
   import acc_datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] acc_out,
   output logic             busy,
   output logic             done,
   output logic             carry,
   output logic             zero
);
   localparam int HALF = WIDTH / 2;

   logic [WIDTH-1:0] acc_q, acc_d, mul_product;
   logic             carry_q, carry_d, done_q;
   logic             accept, alu_accept, mul_start, mul_busy, mul_done;

   assign op_ready   = !mul_busy;
   assign accept     = op_valid && op_ready;
   assign mul_start  = accept && (op_code == OP_MUL);
   assign alu_accept = accept && (op_code != OP_MUL);

   shift_add_multiplier #(.HALF(HALF)) u_mul (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (mul_start),
      .a           (acc_q[HALF-1:0]),
      .b           (data_in[HALF-1:0]),
      .product     (mul_product),
      .busy        (mul_busy),
      .done_strobe (mul_done)
   );

   always_comb begin
      acc_d   = acc_q;
      carry_d = carry_q;
      case (op_code)
         OP_CLR:  begin acc_d = '0; carry_d = 1'b0; end
         OP_SHR:  begin acc_d = acc_q >> 1; carry_d = acc_q[0]; end
         OP_ADD:  {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data_in};
         OP_INC:  {carry_d, acc_d} = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
         OP_SWAP: acc_d = {acc_q[HALF-1:0], acc_q[WIDTH-1:HALF]};
         OP_CMP:  acc_d = ~acc_q;
         default: ;
      endcase
   end

   // multiply commit and ALU accept are exclusive: no accept happens while busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q   <= '0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= alu_accept || mul_done;
         if (mul_done) begin
            acc_q <= mul_product;
         end else if (alu_accept) begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
         end
      end
   end

   assign acc_out = acc_q;
   assign carry   = carry_q;
   assign done    = done_q;
   assign busy    = mul_busy;
   assign zero    = (acc_q == '0);
endmodule

// File: tb/tb_acc_datapath_param.sv
// Directed bench for acc_datapath_param at WIDTH=16 with hand-computed expectations.
module tb_acc_datapath_param;
   import acc_datapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, op_valid, op_ready, busy, done, carry, zero;
   logic [2:0]  op_code;
   logic [15:0] data_in, acc_out;
   int          nvec = 0;
   int          nerr = 0;

   acc_datapath_param #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .data_in(data_in), .acc_out(acc_out), .busy(busy),
      .done(done), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the next negedge with the op applied
   task automatic issue(input logic [2:0] code, input logic [15:0] d);
      op_valid = 1'b1;
      op_code  = code;
      data_in  = d;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; op_valid = 1'b0; op_code = OP_NOP; data_in = '0;
      @(negedge clk); idle_cycle();
      rst_n = 1'b1;
      chk("rst_acc",   32'(acc_out), 32'h0);
      chk("rst_carry", 32'(carry), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_ready", 32'(op_ready), 32'h1);
      chk("rst_zero",  32'(zero), 32'h1);

      // back-to-back ADD, INC
      issue(OP_ADD, 16'h1234);
      chk("add_acc",   32'(acc_out), 32'h1234);
      chk("add_done",  32'(done), 32'h1);
      chk("add_ready", 32'(op_ready), 32'h1);
      issue(OP_INC, 16'h0000);
      chk("inc_acc",   32'(acc_out), 32'h1235);
      chk("inc_carry", 32'(carry), 32'h0);
      chk("inc_done",  32'(done), 32'h1);
      chk("inc_ready", 32'(op_ready), 32'h1);
      idle_cycle();
      chk("done_drop", 32'(done), 32'h0);

      // ADD overflow wraps to zero with carry
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'h0001);
      issue(OP_ADD, 16'hFFFF);
      chk("ovf_acc",   32'(acc_out), 32'h0);
      chk("ovf_carry", 32'(carry), 32'h1);
      chk("ovf_zero",  32'(zero), 32'h1);
      issue(OP_CLR, 16'h0);
      chk("clr_carry", 32'(carry), 32'h0);

      // INC of all-ones
      issue(OP_CMP, 16'h0);
      chk("cmp0_acc", 32'(acc_out), 32'hFFFF);
      issue(OP_INC, 16'h0);
      chk("incw_acc",   32'(acc_out), 32'h0);
      chk("incw_carry", 32'(carry), 32'h1);
      chk("incw_zero",  32'(zero), 32'h1);

      // SWAP / CMP / SHR
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'h1234);
      issue(OP_SWAP, 16'h0);
      chk("swap_acc", 32'(acc_out), 32'h3412);
      issue(OP_CMP, 16'h0);
      chk("cmp_acc", 32'(acc_out), 32'hCBED);
      chk("cmp_zero", 32'(zero), 32'h0);
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'h0003);
      issue(OP_SHR, 16'h0);
      chk("shr_acc",   32'(acc_out), 32'h0001);
      chk("shr_carry", 32'(carry), 32'h1);
      issue(OP_NOP, 16'hFFFF);
      chk("nop_acc",   32'(acc_out), 32'h0001);
      chk("nop_carry", 32'(carry), 32'h1);

      // MUL 0x0F*0x0F with upper bits ignored, ADD mid-multiply dropped
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'hAB0F);
      issue(OP_MUL, 16'h120F);
      for (int i = 0; i < 8; i++) begin
         chk("mul1_busy",  32'(busy), 32'h1);
         chk("mul1_ready", 32'(op_ready), 32'h0);
         chk("mul1_hold",  32'(acc_out), 32'hAB0F);
         chk("mul1_nodone", 32'(done), 32'h0);
         op_valid = (i == 2);
         op_code  = OP_ADD;
         data_in  = 16'h1111;
         idle_cycle();
         op_valid = 1'b0;
      end
      chk("mul1_acc",   32'(acc_out), 32'h00E1);
      chk("mul1_done",  32'(done), 32'h1);
      chk("mul1_busy0", 32'(busy), 32'h0);
      chk("mul1_carry", 32'(carry), 32'h0);
      idle_cycle();
      chk("mul1_pulse", 32'(done), 32'h0);
      chk("mul1_keep",  32'(acc_out), 32'h00E1);

      // MUL 0xFF*0xFF with carry=1 held across
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'h0100);
      issue(OP_ADD, 16'hFFFF);
      chk("pre2_acc",   32'(acc_out), 32'h00FF);
      chk("pre2_carry", 32'(carry), 32'h1);
      issue(OP_MUL, 16'h00FF);
      for (int i = 0; i < 7; i++) idle_cycle();
      chk("mul2_n7_acc",  32'(acc_out), 32'h00FF);
      chk("mul2_n7_busy", 32'(busy), 32'h1);
      idle_cycle();
      chk("mul2_acc",   32'(acc_out), 32'hFE01);
      chk("mul2_carry", 32'(carry), 32'h1);
      chk("mul2_done",  32'(done), 32'h1);

      // reset during the 4th multiply cycle aborts silently
      issue(OP_CLR, 16'h0);
      issue(OP_ADD, 16'h0005);
      issue(OP_MUL, 16'h0003);
      idle_cycle(); idle_cycle(); idle_cycle();
      chk("mul3_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      idle_cycle();
      rst_n = 1'b1;
      chk("abort_acc",   32'(acc_out), 32'h0);
      chk("abort_busy",  32'(busy), 32'h0);
      chk("abort_ready", 32'(op_ready), 32'h1);
      chk("abort_done",  32'(done), 32'h0);
      idle_cycle();
      chk("abort_done2", 32'(done), 32'h0);

      issue(OP_ADD, 16'h0005);
      issue(OP_MUL, 16'h0003);
      for (int i = 0; i < 8; i++) begin
         chk("mul4_busy", 32'(busy), 32'h1);
         idle_cycle();
      end
      chk("mul4_acc",  32'(acc_out), 32'h000F);
      chk("mul4_done", 32'(done), 32'h1);
      chk("mul4_ready", 32'(op_ready), 32'h1);

      // accept in the same cycle done is high
      issue(OP_INC, 16'h0);
      chk("post_inc", 32'(acc_out), 32'h0010);
      chk("post_done", 32'(done), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
